// File: rtl/rcn_pkg.sv
// Shared definitions for the RCN byte-FIFO arbitration blocks.
// Byte-lane width and the arbiter FSM state encoding.
package rcn_pkg;

  localparam int RCN_BYTE_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } rcn_state_t;

endpackage

// File: rtl/rcn_rr_pick.sv
// Combinational round-robin picker: one-hot select of the first asserted request
// found by scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
module rcn_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] pick
);

  logic found;
  int   idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rcn_fifo_byte_arb.sv
// Packet-atomic round-robin arbiter sharing one byte-FIFO push port among N_REQ
// byte-stream requesters, with an idle watchdog that reclaims a stalled grant.
module rcn_fifo_byte_arb
  import rcn_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 63,
  parameter int CW      = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [RCN_BYTE_W*N_REQ-1:0]  req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic [N_REQ-1:0]             grant,
  output logic [RCN_BYTE_W-1:0]        fifo_din,
  output logic                         fifo_push,
  input  logic                         fifo_full,
  output logic                         timeout
);

  localparam int            PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam bit            WD_ON   = (TIMEOUT > 0);
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  rcn_state_t        state, state_nxt;
  logic [N_REQ-1:0]  grant_nxt;
  logic [N_REQ-1:0]  pick;
  logic [PW-1:0]     rr_ptr, rr_ptr_nxt;
  logic [PW-1:0]     owner_idx;
  logic [PW-1:0]     ptr_after;
  logic [CW-1:0]     wdog, wdog_nxt;
  logic              timeout_nxt;
  logic              owner_valid;
  logic              owner_last;
  logic              xfer;
  logic              wd_expire;

  rcn_rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .pick   (pick)
  );

  // Lane view of the current owner; grant is all-zero in IDLE so every term is 0 there.
  assign owner_valid = |(req_valid & grant);
  assign owner_last  = |(req_last & grant);
  assign xfer        = owner_valid & ~fifo_full;

  assign req_ready = grant & {N_REQ{~fifo_full}};
  assign fifo_push = xfer;

  always_comb begin
    fifo_din = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) fifo_din = fifo_din | req_data[i*RCN_BYTE_W +: RCN_BYTE_W];
    end
  end

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) owner_idx = PW'(i);
    end
  end

  assign ptr_after = (owner_idx == PW'(N_REQ - 1)) ? '0 : owner_idx + PW'(1);
  assign wd_expire = WD_ON && !owner_valid && (wdog == WD_LAST);

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    rr_ptr_nxt  = rr_ptr;
    wdog_nxt    = wdog;
    timeout_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        wdog_nxt = '0;
        if (|req_valid) begin
          grant_nxt = pick;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (xfer) begin
          wdog_nxt = '0;
          if (owner_last) begin
            grant_nxt  = '0;
            rr_ptr_nxt = ptr_after;
            state_nxt  = ST_IDLE;
          end
        end else if (!owner_valid) begin
          // Only an absent byte counts as idle; a full-FIFO stall just holds wdog.
          if (wd_expire) begin
            grant_nxt   = '0;
            rr_ptr_nxt  = ptr_after;
            state_nxt   = ST_IDLE;
            wdog_nxt    = '0;
            timeout_nxt = 1'b1;
          end else begin
            wdog_nxt = wdog + CW'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
        wdog_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      wdog    <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      rr_ptr  <= rr_ptr_nxt;
      wdog    <= wdog_nxt;
      timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rcn_fifo_byte_arb.sv
// Directed bench for rcn_fifo_byte_arb: vector table plus watchdog sequences.
module tb_rcn_fifo_byte_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic [7:0]  fifo_din;
  logic        fifo_push;
  logic        fifo_full;
  logic        timeout;

  int nvec = 0;
  int nerr = 0;

  rcn_fifo_byte_arb #(.N_REQ(4), .TIMEOUT(63), .CW(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .fifo_din  (fifo_din),
    .fifo_push (fifo_push),
    .fifo_full (fifo_full),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        full;
    logic [3:0]  e_grant;
    logic [3:0]  e_ready;
    logic        e_push;
    logic [7:0]  e_din;
    logic        e_to;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [3:0] v, logic [31:0] d, logic [3:0] l,
                              logic f, logic [3:0] g, logic [3:0] rd, logic p,
                              logic [7:0] dn, logic t);
    vec_t x;
    x.rst_n = r; x.valid = v; x.data = d; x.last = l; x.full = f;
    x.e_grant = g; x.e_ready = rd; x.e_push = p; x.e_din = dn; x.e_to = t;
    return x;
  endfunction

  task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] d,
                       input logic [3:0] l, input logic f);
    rst_n = r; req_valid = v; req_data = d; req_last = l; fifo_full = f;
  endtask

  task automatic chk(input string nm, input logic [3:0] g, input logic [3:0] rd,
                     input logic p, input logic [7:0] dn, input logic t);
    nvec++;
    if (grant !== g || req_ready !== rd || fifo_push !== p || fifo_din !== dn || timeout !== t) begin
      nerr++;
      $display("FAIL %s: got grant=%b ready=%b push=%b din=%h to=%b, want grant=%b ready=%b push=%b din=%h to=%b",
               nm, grant, req_ready, fifo_push, fifo_din, timeout, g, rd, p, dn, t);
    end
    if (fifo_push === 1'b1 && fifo_full === 1'b1) begin
      nerr++;
      $display("FAIL %s_push_while_full: got push=1 full=1, want push=0", nm);
    end
  endtask

  // Apply inputs just after a posedge, check on the negedge, then advance.
  task automatic step(input string nm, input logic r, input logic [3:0] v, input logic [31:0] d,
                      input logic [3:0] l, input logic f, input logic [3:0] g,
                      input logic [3:0] rd, input logic p, input logic [7:0] dn, input logic t);
    drive(r, v, d, l, f);
    @(negedge clk);
    chk(nm, g, rd, p, dn, t);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 4'b0, 32'h0, 4'b0, 1'b0);

    // reset, then lane0 AA/BB/CC, bubble, lane2
    tbl.push_back(mk(0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(mk(1, 4'b0101, 32'h001100AA, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(mk(1, 4'b0101, 32'h001100AA, 4'b0000, 0, 4'b0001, 4'b0001, 1, 8'hAA, 0));
    tbl.push_back(mk(1, 4'b0101, 32'h001100BB, 4'b0000, 0, 4'b0001, 4'b0001, 1, 8'hBB, 0));
    tbl.push_back(mk(1, 4'b0101, 32'h001100CC, 4'b0001, 0, 4'b0001, 4'b0001, 1, 8'hCC, 0));
    tbl.push_back(mk(1, 4'b0100, 32'h00110000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(mk(1, 4'b0100, 32'h00110000, 4'b0100, 0, 4'b0100, 4'b0100, 1, 8'h11, 0));
    // reset, then all lanes valid with 1-byte packets: 0,1,2,3,0
    tbl.push_back(mk(0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(mk(1, 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(mk(1, 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 4'b0001, 4'b0001, 1, 8'hA0, 0));
    tbl.push_back(mk(1, 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(mk(1, 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 4'b0010, 4'b0010, 1, 8'hA1, 0));
    tbl.push_back(mk(1, 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(mk(1, 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 4'b0100, 4'b0100, 1, 8'hA2, 0));
    tbl.push_back(mk(1, 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(mk(1, 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 4'b1000, 4'b1000, 1, 8'hA3, 0));
    tbl.push_back(mk(1, 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(mk(1, 4'b1111, 32'hA3A2A1A0, 4'b1111, 0, 4'b0001, 4'b0001, 1, 8'hA0, 0));
    // lane1 packet with a 5-cycle fifo_full stall
    tbl.push_back(mk(1, 4'b0010, 32'h00005500, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(mk(1, 4'b0010, 32'h00005500, 4'b0000, 0, 4'b0010, 4'b0010, 1, 8'h55, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 4'b0010, 32'h00006600, 4'b0000, 1, 4'b0010, 4'b0000, 0, 8'h66, 0));
    tbl.push_back(mk(1, 4'b0010, 32'h00006600, 4'b0010, 0, 4'b0010, 4'b0010, 1, 8'h66, 0));
    // lane2 mid-packet reset; afterwards lane0 wins despite lane2 still valid
    tbl.push_back(mk(1, 4'b0101, 32'h00770088, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(mk(1, 4'b0101, 32'h00770088, 4'b0000, 0, 4'b0100, 4'b0100, 1, 8'h77, 0));
    tbl.push_back(mk(0, 4'b0101, 32'h00770088, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(mk(1, 4'b0101, 32'h00770088, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(mk(1, 4'b0101, 32'h00770088, 4'b0001, 0, 4'b0001, 4'b0001, 1, 8'h88, 0));

    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      step($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].valid, tbl[i].data, tbl[i].last,
           tbl[i].full, tbl[i].e_grant, tbl[i].e_ready, tbl[i].e_push, tbl[i].e_din, tbl[i].e_to);
    end

    // Watchdog: lane2 granted, then 63 idle cycles -> timeout pulse, lane3 next
    step("wd_req", 1, 4'b0100, 32'h00330000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
    for (int k = 0; k < 63; k++)
      step($sformatf("wd_idle%0d", k), 1, 4'b0000, 32'h0, 4'b0000, 0,
           4'b0100, 4'b0100, 0, 8'h00, 0);
    step("wd_pulse", 1, 4'b1000, 32'h44000000, 4'b1000, 0, 4'b0000, 4'b0000, 0, 8'h00, 1);
    step("wd_next", 1, 4'b1000, 32'h44000000, 4'b1000, 0, 4'b1000, 4'b1000, 1, 8'h44, 0);

    // Last byte lands on the cycle the watchdog would expire -> normal release
    step("sim_req", 1, 4'b0001, 32'h00000099, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
    for (int k = 0; k < 62; k++)
      step($sformatf("sim_idle%0d", k), 1, 4'b0000, 32'h0, 4'b0000, 0,
           4'b0001, 4'b0001, 0, 8'h00, 0);
    step("sim_last", 1, 4'b0001, 32'h00000099, 4'b0001, 0, 4'b0001, 4'b0001, 1, 8'h99, 0);
    step("sim_after", 1, 4'b0000, 32'h0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
